// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU, with an architectural flag register.
// Latency: grant in cycle T, response valid in T+2; at most one operation in flight (1 op / 3 cycles peak).
// Backpressure: response holds in RESP until rsp_ready; no new grant is issued until that handshake.
module alu_arbiter #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    input  logic          alu_err,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    state_e     state_q, state_d;
    logic       last_q, last_d;     // requester granted most recently
    cmd_t       cmd_q, cmd_d;       // operation presented to the ALU
    rsp_t       rsp_q, rsp_d;       // captured response
    logic [2:0] flags_q, flags_d;   // {Z, V, N}

    logic       gnt_vld;
    logic       gnt_id;
    cmd_t       gnt_cmd;

    // Round-robin pick in IDLE: a tie goes to the requester not granted last; nothing is granted in reset
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_q;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign gnt_cmd    = gnt_id ? {req1_op, req1_a, req1_b} : {req0_op, req0_a, req0_b};
    assign req0_ready = gnt_vld & ~gnt_id;
    assign req1_ready = gnt_vld & gnt_id;

    // Next state: latch the winner on grant, capture the ALU result and update flags in EXEC, drain in RESP
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        rsp_d   = rsp_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d  = EXEC;
                    last_d   = gnt_id;
                    cmd_d    = gnt_cmd;
                    rsp_d.id = gnt_id;
                end
            end
            EXEC: begin
                state_d   = RESP;
                rsp_d.dat = alu_out;
                rsp_d.err = alu_err;
                // An erroring operation leaves the flags untouched; XOR only defines Z
                if (!alu_err) begin
                    case (cmd_q.op)
                        3'd0, 3'd1: flags_d    = alu_flags;
                        3'd2:       flags_d[2] = alu_flags[2];
                        default:    flags_d    = flags_q;
                    endcase
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; pointer resets to 1 so req0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            rsp_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            rsp_q   <= rsp_d;
            flags_q <= flags_d;
        end
    end

    assign alu_op    = cmd_q.op;
    assign alu_in1   = cmd_q.a;
    assign alu_in2   = cmd_q.b;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_q.id;
    assign rsp_data  = rsp_q.dat;
    assign rsp_err   = rsp_q.err;
    assign flag_z    = flags_q[2];
    assign flag_v    = flags_q[1];
    assign flag_n    = flags_q[0];
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences, randomized run vs. transaction model.
// Latency: expects grant at T, rsp_valid at T+2; inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: rsp_ready is held low for stretches to exercise the RESP hold behaviour.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_op, alu_flags;
    logic        tb_err;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;
    logic        flag_z, flag_v, flag_n, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags), .alu_err(tb_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .busy(busy)
    );

    // Behavioural ALU: signed saturating ADD/SUB, XOR, other ops pass operand a. Returns {Z,V,N,result}.
    function automatic logic [18:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        logic [15:0] res;
        logic v;
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        r  = sa;
        v  = 1'b0;
        if (op == 3'd0) r = sa + sb;
        else if (op == 3'd1) r = sa - sb;
        if (op <= 3'd1) begin
            if (r > 32767) begin r = 32767; v = 1'b1; end
            else if (r < -32768) begin r = -32768; v = 1'b1; end
        end
        res = r[15:0];
        if (op == 3'd2) res = a ^ b;
        return {(res == 16'h0000), v, res[15], res};
    endfunction

    always_comb {alu_flags, alu_out} = alu_model(alu_op, alu_in1, alu_in2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Let any in-flight operation complete and return to IDLE
    task automatic drain();
        bit idle;
        @(posedge clk); #1;
        drive_idle();
        rsp_ready = 1'b1;
        tb_err    = 1'b0;
        idle      = 1'b0;
        for (int n = 0; n < 10 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk("drain_to_idle", idle, 1'b1);
    endtask

    typedef struct {
        bit          id;
        logic [2:0]  op;
        logic [15:0] a, b;
        bit          err;
        logic [15:0] exp_data;
        bit          exp_err, exp_z, exp_v, exp_n;
    } vec_t;

    // Single request from one requester with rsp_ready high; checks latency, ALU operands, response and flags
    task automatic run_txn(input vec_t v);
        bit seen;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        tb_err    = v.err;
        if (v.id == 1'b0) begin req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
        else begin req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if ((v.id == 1'b0 && req0_ready) || (v.id == 1'b1 && req1_ready)) seen = 1'b1;
        end
        chk("vec_grant", seen, 1'b1);
        chk("vec_other_ready", (v.id == 1'b0) ? req1_ready : req0_ready, 1'b0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("vec_exec_no_rsp", rsp_valid, 1'b0);
        chk("vec_alu_in1", alu_in1, v.a);
        chk("vec_alu_in2", alu_in2, v.b);
        chk("vec_alu_op", alu_op, v.op);
        @(negedge clk);
        chk("vec_rsp_valid_t2", rsp_valid, 1'b1);
        chk("vec_rsp_id", rsp_id, v.id);
        chk("vec_rsp_data", rsp_data, v.exp_data);
        chk("vec_rsp_err", rsp_err, v.exp_err);
        chk("vec_flags_zvn", {flag_z, flag_v, flag_n}, {v.exp_z, v.exp_v, v.exp_n});
        @(posedge clk); #1;
        tb_err = 1'b0;
    endtask

    vec_t vecs[11];

    // Randomized-phase transaction model
    bit          m_busy, m_last, m_err, m_id;
    int          m_age, eg;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b, m_data;
    logic [2:0]  m_res_f;
    logic [2:0]  m_flags;
    logic [18:0] r;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // id, op, a, b, err, exp_data, exp_err, z, v, n
        vecs[0]  = '{1'b0, 3'd0, 16'h7000, 16'h2000, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 3'd2, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 3'd0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 3'd5, 16'h1234, 16'h5678, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 3'd2, 16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 3'd1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset with both requesters already asking for SUB 5-5
        rst_n = 1'b0; rsp_ready = 1'b1; tb_err = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h0005; req0_b = 16'h0005;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 16'h0005; req1_b = 16'h0005;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req0_ready", req0_ready, 1'b0);
        chk("reset_req1_ready", req1_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_fields", {rsp_id, rsp_err, rsp_data}, 18'h0);
        chk("reset_alu_regs", {alu_op, alu_in1, alu_in2}, 35'h0);
        chk("reset_flags", {flag_z, flag_v, flag_n}, 3'b000);

        // Continuous tie from reset: grants alternate starting with req0
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit seen;
            bit gid;
            seen = 1'b0; gid = 1'b0;
            for (int n = 0; n < 8 && !seen; n++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin seen = 1'b1; gid = req1_ready; end
            end
            chk("tie_grant_seen", seen, 1'b1);
            chk("tie_grant_id", gid, k[0]);
            chk("tie_single_ready", req0_ready & req1_ready, 1'b0);
            @(negedge clk);
            @(negedge clk);
            chk("tie_rsp_id", {rsp_valid, rsp_id}, {1'b1, k[0]});
            chk("tie_rsp_data", rsp_data, 16'h0000);
            chk("tie_flag_z", flag_z, 1'b1);
        end
        drain();

        // Directed vector table
        foreach (vecs[i]) run_txn(vecs[i]);

        // Backpressure: response held 5 cycles while req1 waits
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 16'h1234; req0_b = 16'h00FF;
        @(negedge clk);
        chk("bp_grant", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h0001; req1_b = 16'h0002;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 16'h12CB);
            chk("bp_ready_low", {req0_ready, req1_ready}, 2'b00);
            chk("bp_busy", busy, 1'b1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_valid", rsp_valid, 1'b1);
        @(negedge clk);
        chk("bp_after_hs_valid", rsp_valid, 1'b0);
        chk("bp_next_grant_req1", req1_ready, 1'b1);
        drain();

        // Reset while in RESP: response discarded, flags cleared, pointer back so req0 wins the tie
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h7000; req0_b = 16'h2000;
        @(negedge clk);
        chk("rr_grant_req0", req0_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h0003; req1_b = 16'h0004;
        @(negedge clk);
        @(negedge clk);
        chk("rr_in_resp", {rsp_valid, flag_v}, 2'b11);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_rsp_valid", rsp_valid, 1'b0);
        chk("rr_busy", busy, 1'b0);
        chk("rr_flags", {flag_z, flag_v, flag_n}, 3'b000);
        chk("rr_tie_to_req0", {req0_ready, req1_ready}, 2'b10);
        drain();

        // Randomized run checked against a transaction-level model
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_busy = 1'b0; m_last = 1'b1; m_flags = 3'b000; m_age = 0; m_err = 1'b0;
        m_id = 1'b0; m_op = 3'd0; m_a = '0; m_b = '0; m_data = '0; m_res_f = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_op = 3'($urandom_range(0, 7)); req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_op = 3'($urandom_range(0, 7)); req1_a = 16'($urandom); req1_b = 16'($urandom);
            rsp_ready = ($urandom_range(0, 1) == 1);
            tb_err    = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (!m_busy) begin
                eg = -1;
                if (req0_valid && req1_valid) eg = m_last ? 0 : 1;
                else if (req0_valid) eg = 0;
                else if (req1_valid) eg = 1;
                chk("rnd_req0_ready", req0_ready, (eg == 0));
                chk("rnd_req1_ready", req1_ready, (eg == 1));
                chk("rnd_idle_busy", busy, 1'b0);
                if (eg >= 0) begin
                    m_busy = 1'b1; m_age = 0; m_id = (eg == 1); m_last = m_id;
                    m_op = m_id ? req1_op : req0_op;
                    m_a  = m_id ? req1_a  : req0_a;
                    m_b  = m_id ? req1_b  : req0_b;
                    r = alu_model(m_op, m_a, m_b);
                    m_data = r[15:0]; m_res_f = r[18:16];
                end
            end else begin
                m_age++;
                chk("rnd_busy_ready", {req0_ready, req1_ready}, 2'b00);
                chk("rnd_busy", busy, 1'b1);
                chk("rnd_alu_ops", {alu_op, alu_in1, alu_in2}, {m_op, m_a, m_b});
                if (m_age == 1) begin
                    chk("rnd_exec_no_rsp", rsp_valid, 1'b0);
                    m_err = tb_err;
                end else begin
                    if (m_age == 2 && !m_err) begin
                        if (m_op <= 3'd1) m_flags = m_res_f;
                        else if (m_op == 3'd2) m_flags[2] = m_res_f[2];
                    end
                    chk("rnd_rsp_valid", rsp_valid, 1'b1);
                    chk("rnd_rsp", {rsp_id, rsp_err, rsp_data}, {m_id, m_err, m_data});
                    if (rsp_ready) m_busy = 1'b0;
                end
            end
            chk("rnd_flags", {flag_z, flag_v, flag_n}, m_flags);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
